// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store initiator for a 32-bit word memory.
// Turns byte/half/word requests into word cycles. Sub-word stores use a
// read-modify-write sequence. Loads return aligned, extended data.
module mem_access_ctrl #(
   parameter int unsigned WORD_INDEXED = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        misaligned,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out
);

   typedef enum logic [1:0] {IDLE, RD, RDATA, WR} state_t;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD} size_t;

   state_t      state;
   size_t       req_sz;
   size_t       lat_size;
   logic        lat_write;
   logic        lat_signed;
   logic [1:0]  lat_off;
   logic [15:0] lat_wdata;

   logic        req_misal;
   logic [31:0] word_addr;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [31:0] load_data;
   logic [31:0] merged;

   // Strobes follow the state directly; reset suppresses them in the same cycle.
   assign stall     = (state != IDLE);
   assign mem_read  = (state == RD) & ~reset;
   assign mem_write = (state == WR) & ~reset;

   assign req_sz = size_t'(req_size);

   // Classify the incoming request and form its memory address.
   always_comb begin
      req_misal = 1'b0;
      case (req_sz)
         SZ_HALF: req_misal = req_addr[0];
         SZ_WORD: req_misal = |req_addr[1:0];
         SZ_BAD:  req_misal = 1'b1;
         default: req_misal = 1'b0;
      endcase
      if (WORD_INDEXED != 0)
         word_addr = {2'b00, req_addr[31:2]};
      else
         word_addr = {req_addr[31:2], 2'b00};
   end

   // Lane extraction for loads and lane merge for sub-word stores.
   always_comb begin
      sel_byte = '0;
      case (lat_off)
         2'd0: sel_byte = mem_data_out[7:0];
         2'd1: sel_byte = mem_data_out[15:8];
         2'd2: sel_byte = mem_data_out[23:16];
         2'd3: sel_byte = mem_data_out[31:24];
         default: sel_byte = '0;
      endcase
      sel_half = lat_off[1] ? mem_data_out[31:16] : mem_data_out[15:0];

      load_data = mem_data_out;
      case (lat_size)
         SZ_BYTE: load_data = {{24{lat_signed & sel_byte[7]}}, sel_byte};
         SZ_HALF: load_data = {{16{lat_signed & sel_half[15]}}, sel_half};
         default: load_data = mem_data_out;
      endcase

      merged = mem_data_out;
      case (lat_size)
         SZ_BYTE: begin
            case (lat_off)
               2'd0: merged[7:0]   = lat_wdata[7:0];
               2'd1: merged[15:8]  = lat_wdata[7:0];
               2'd2: merged[23:16] = lat_wdata[7:0];
               2'd3: merged[31:24] = lat_wdata[7:0];
               default: merged = mem_data_out;
            endcase
         end
         SZ_HALF: begin
            if (lat_off[1])
               merged[31:16] = lat_wdata;
            else
               merged[15:0]  = lat_wdata;
         end
         default: merged = mem_data_out;
      endcase
   end

   // Access sequencer with registered response and memory address/data.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         resp_valid  <= 1'b0;
         resp_rdata  <= '0;
         misaligned  <= 1'b0;
         mem_address <= '0;
         mem_data_in <= '0;
         lat_size    <= SZ_BYTE;
         lat_write   <= 1'b0;
         lat_signed  <= 1'b0;
         lat_off     <= '0;
         lat_wdata   <= '0;
      end else begin
         resp_valid <= 1'b0;
         misaligned <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_size   <= req_sz;
                  lat_write  <= req_write;
                  lat_signed <= req_signed;
                  lat_off    <= req_addr[1:0];
                  lat_wdata  <= req_wdata[15:0];
                  if (req_misal) begin
                     resp_valid <= 1'b1;
                     misaligned <= 1'b1;
                     resp_rdata <= '0;
                  end else begin
                     mem_address <= word_addr;
                     if (req_write && req_sz == SZ_WORD) begin
                        mem_data_in <= req_wdata;
                        state       <= WR;
                     end else begin
                        state <= RD;
                     end
                  end
               end
            end
            RD: state <= RDATA;
            RDATA: begin
               if (lat_write) begin
                  mem_data_in <= merged;
                  state       <= WR;
               end else begin
                  resp_rdata <= load_data;
                  resp_valid <= 1'b1;
                  state      <= IDLE;
               end
            end
            WR: begin
               mem_data_in <= '0;
               resp_valid  <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of mem_access_ctrl against a small
// registered-read word memory and hand-computed expected results.
module tb_mem_access_ctrl;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        misaligned;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out;

   logic        mem_init;
   logic [31:0] mem [0:15];

   int n_cmp = 0;
   int n_err = 0;

   int          r_lat, r_nrd, r_nwr;
   logic        r_stall_ok, r_mis, r_done;
   logic [31:0] r_rdata, r_rd_addr, r_wr_addr, r_wr_data;

   mem_access_ctrl #(.WORD_INDEXED(1)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_signed   (req_signed),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .stall        (stall),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .misaligned   (misaligned),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word memory: registered read data one cycle after mem_read, x otherwise.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
         mem[2] <= 32'h80FF7F01;
         mem[3] <= 32'h11223344;
         mem[5] <= 32'hDEADBEEF;
      end else if (mem_write) begin
         mem[mem_address[3:0]] <= mem_data_in;
      end
      mem_data_out <= mem_read ? mem[mem_address[3:0]] : 32'hxxxxxxxx;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present a request at the current negedge and follow it to resp_valid.
   task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input bit junk);
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      r_lat = 0; r_nrd = 0; r_nwr = 0;
      r_stall_ok = 1'b1; r_mis = 1'b0; r_done = 1'b0;
      r_rdata = '0; r_rd_addr = '0; r_wr_addr = '0; r_wr_data = '0;
      for (int c = 1; c <= 10 && !r_done; c++) begin
         @(negedge clk);
         if (mem_read) begin
            r_nrd++;
            r_rd_addr = mem_address;
         end
         if (mem_write) begin
            r_nwr++;
            r_wr_addr = mem_address;
            r_wr_data = mem_data_in;
         end
         if (resp_valid) begin
            r_done  = 1'b1;
            r_lat   = c;
            r_rdata = resp_rdata;
            r_mis   = misaligned;
            if (stall) r_stall_ok = 1'b0;
            req_valid = 1'b0;
         end else begin
            if (!stall) r_stall_ok = 1'b0;
            if (junk) begin
               req_valid = 1'b1;
               req_write = 1'b1;
               req_size  = 2'b10;
               req_addr  = 32'h0000000C;
               req_wdata = 32'hFFFFFFFF;
            end else begin
               req_valid = 1'b0;
            end
         end
      end
   endtask

   task automatic expect_req(input string tag, input int elat, input int enrd, input int enwr,
                             input logic [31:0] eaddr, input logic [31:0] edata, input logic emis);
      check({tag, ".done"}, 32'(r_done), 32'd1);
      check({tag, ".lat"}, r_lat, elat);
      check({tag, ".stall"}, 32'(r_stall_ok), 32'd1);
      check({tag, ".nrd"}, r_nrd, enrd);
      check({tag, ".nwr"}, r_nwr, enwr);
      check({tag, ".mis"}, 32'(r_mis), 32'(emis));
      if (enrd > 0) check({tag, ".rdaddr"}, r_rd_addr, eaddr);
      if (enwr > 0) begin
         check({tag, ".wraddr"}, r_wr_addr, eaddr);
         check({tag, ".wrdata"}, r_wr_data, edata);
      end else begin
         check({tag, ".rdata"}, r_rdata, edata);
      end
   endtask

   initial begin
      int seen;
      reset = 1'b1; mem_init = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst.mem_read", 32'(mem_read), 32'd0);
      reset = 1'b0; mem_init = 1'b0;
      @(negedge clk);
      check("rst.stall", 32'(stall), 32'd0);
      check("rst.resp_valid", 32'(resp_valid), 32'd0);
      check("rst.resp_rdata", resp_rdata, 32'd0);
      check("rst.misaligned", 32'(misaligned), 32'd0);
      check("rst.mem_write", 32'(mem_write), 32'd0);
      check("rst.mem_address", mem_address, 32'd0);
      check("rst.mem_data_in", mem_data_in, 32'd0);

      // Loads
      @(negedge clk); run_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0);
      expect_req("wload", 3, 1, 0, 32'd5, 32'hDEADBEEF, 1'b0);
      @(negedge clk); run_req(1'b0, 2'b00, 1'b1, 32'h0B, 32'h0, 1'b0);
      expect_req("lb_s", 3, 1, 0, 32'd2, 32'hFFFFFF80, 1'b0);
      @(negedge clk); run_req(1'b0, 2'b00, 1'b0, 32'h0B, 32'h0, 1'b0);
      expect_req("lb_u", 3, 1, 0, 32'd2, 32'h00000080, 1'b0);
      @(negedge clk); run_req(1'b0, 2'b01, 1'b1, 32'h08, 32'h0, 1'b0);
      expect_req("lh_s0", 3, 1, 0, 32'd2, 32'h00007F01, 1'b0);
      @(negedge clk); run_req(1'b0, 2'b01, 1'b1, 32'h0A, 32'h0, 1'b0);
      expect_req("lh_s1", 3, 1, 0, 32'd2, 32'hFFFF80FF, 1'b0);

      // Byte store RMW; response data stays from the previous load
      @(negedge clk); run_req(1'b1, 2'b00, 1'b0, 32'h0D, 32'h000000AA, 1'b0);
      expect_req("sb", 4, 1, 1, 32'd3, 32'h1122AA44, 1'b0);
      check("sb.rdata_kept", resp_rdata, 32'hFFFF80FF);
      check("sb.mem_data_in_idle", mem_data_in, 32'd0);
      check("sb.mem3", mem[3], 32'h1122AA44);

      // Word store
      @(negedge clk); run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEBABE, 1'b0);
      expect_req("sw", 2, 0, 1, 32'd4, 32'hCAFEBABE, 1'b0);
      check("sw.mem4", mem[4], 32'hCAFEBABE);

      // Misaligned and illegal size
      @(negedge clk); run_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b0);
      expect_req("mis_w", 1, 0, 0, 32'd0, 32'd0, 1'b1);
      check("mis_w.addr_held", mem_address, 32'd4);
      @(negedge clk); run_req(1'b1, 2'b01, 1'b0, 32'h09, 32'h1234, 1'b0);
      expect_req("mis_h", 1, 0, 0, 32'd0, 32'd0, 1'b1);
      @(negedge clk); run_req(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 1'b0);
      expect_req("mis_sz", 1, 0, 0, 32'd0, 32'd0, 1'b1);

      // Reset while in WR of a half store
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01;
      req_signed = 1'b0; req_addr = 32'h1E; req_wdata = 32'h0000BEEF;
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rstwr.pre_write", 32'(mem_write), 32'd1);
      reset = 1'b1;
      #1;
      check("rstwr.write_gated", 32'(mem_write), 32'd0);
      @(negedge clk); reset = 1'b0;
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (resp_valid) seen++;
      end
      check("rstwr.no_resp", seen, 0);
      check("rstwr.stall", 32'(stall), 32'd0);
      check("rstwr.mem7", mem[7], 32'd0);
      run_req(1'b1, 2'b01, 1'b0, 32'h1E, 32'h0000BEEF, 1'b0);
      expect_req("sh_after", 4, 1, 1, 32'd7, 32'hBEEF0000, 1'b0);
      check("sh_after.mem7", mem[7], 32'hBEEF0000);

      // Busy requests ignored, then back-to-back load in the resp_valid cycle
      @(negedge clk); run_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b1);
      expect_req("busy", 3, 1, 0, 32'd5, 32'hDEADBEEF, 1'b0);
      run_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b0);
      expect_req("b2b", 3, 1, 0, 32'd2, 32'h80FF7F01, 1'b0);
      check("busy.mem3", mem[3], 32'h1122AA44);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
